// File: rtl/wb_stage.sv
// Write-back stage: formats load data, selects the write-back value
// combinationally, and registers the register-file write port for the next cycle.
module wb_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      MemtoReg,
  input  logic [DATA_WIDTH-1:0]     dataReadMEM,
  input  logic [DATA_WIDTH-1:0]     resultALU,
  input  logic [1:0]                memSize,
  input  logic                      RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] writeRegIn,
  output logic [DATA_WIDTH-1:0]     outputWB,
  output logic                      wbWriteEn,
  output logic [REG_ADDR_WIDTH-1:0] wbWriteAddr,
  output logic [DATA_WIDTH-1:0]     wbWriteData
);

  // Byte loads take the low byte only; full-width loads pass straight through.
  function automatic logic [DATA_WIDTH-1:0] formatLoad(
    input logic [DATA_WIDTH-1:0] rawData,
    input logic [1:0]            loadSize
  );
    logic [DATA_WIDTH-1:0] formatted;
    case (loadSize)
      2'b00:   formatted = rawData;
      2'b01:   formatted = {{(DATA_WIDTH-8){rawData[7]}}, rawData[7:0]};
      2'b10:   formatted = {{(DATA_WIDTH-8){1'b0}}, rawData[7:0]};
      2'b11:   formatted = rawData;
      default: formatted = rawData;
    endcase
    return formatted;
  endfunction

  logic [DATA_WIDTH-1:0] memFormatted_s;
  logic                  writeEnNext_s;

  // Select the write-back value; no clock or reset dependence so it stays zero latency.
  always_comb begin
    memFormatted_s = formatLoad(dataReadMEM, memSize);
    if (MemtoReg) begin
      outputWB = memFormatted_s;
    end else begin
      outputWB = resultALU;
    end
  end

  // Register 0 is hard-wired, so a write aimed at it is suppressed here.
  always_comb begin
    writeEnNext_s = 1'b0;
    if (writeRegIn != {REG_ADDR_WIDTH{1'b0}}) begin
      writeEnNext_s = RegWrite;
    end else begin
      writeEnNext_s = 1'b0;
    end
  end

  // Capture the write port every cycle; synchronous active-low reset clears it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wbWriteEn   <= 1'b0;
      wbWriteAddr <= {REG_ADDR_WIDTH{1'b0}};
      wbWriteData <= {DATA_WIDTH{1'b0}};
    end else begin
      wbWriteEn   <= writeEnNext_s;
      wbWriteAddr <= writeRegIn;
      wbWriteData <= outputWB;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases followed by random traffic,
// compared against a behavioural model of the write-back rules.
module tb_wb_stage;

  logic        clock;
  logic        reset;
  logic        MemtoReg;
  logic [15:0] dataReadMEM;
  logic [15:0] resultALU;
  logic [1:0]  memSize;
  logic        RegWrite;
  logic [2:0]  writeRegIn;
  logic [15:0] outputWB;
  logic        wbWriteEn;
  logic [2:0]  wbWriteAddr;
  logic [15:0] wbWriteData;

  int checks = 0;
  int errors = 0;

  logic [15:0] expData;
  logic [2:0]  expAddr;
  logic        expEn;

  wb_stage #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .MemtoReg    (MemtoReg),
    .dataReadMEM (dataReadMEM),
    .resultALU   (resultALU),
    .memSize     (memSize),
    .RegWrite    (RegWrite),
    .writeRegIn  (writeRegIn),
    .outputWB    (outputWB),
    .wbWriteEn   (wbWriteEn),
    .wbWriteAddr (wbWriteAddr),
    .wbWriteData (wbWriteData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected write-back value from the load-format and select rules.
  function automatic logic [15:0] modelWb();
    int b;
    int v;
    b = int'(dataReadMEM[7:0]);
    if (!MemtoReg) return resultALU;
    case (memSize)
      2'b01: begin
        v = (b > 127) ? (b - 256) : b;
        return 16'(v);
      end
      2'b10: return 16'(b);
      default: return dataReadMEM;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic m2r, input logic [15:0] mem,
                       input logic [15:0] alu, input logic [1:0] sz,
                       input logic rw, input logic [2:0] wr);
    reset       = rst;
    MemtoReg    = m2r;
    dataReadMEM = mem;
    resultALU   = alu;
    memSize     = sz;
    RegWrite    = rw;
    writeRegIn  = wr;
  endtask

  // Called just after a falling edge: check comb output, clock once, check registers.
  task automatic cycle(input string tag);
    logic [15:0] nd;
    logic [2:0]  na;
    logic        ne;
    #1;
    chk({tag, "_outputWB"}, outputWB, modelWb());
    if (!reset) begin
      nd = 16'h0000; na = 3'd0; ne = 1'b0;
    end else begin
      nd = modelWb();
      na = writeRegIn;
      ne = RegWrite && (writeRegIn != 3'd0);
    end
    @(posedge clock);
    expData = nd; expAddr = na; expEn = ne;
    #1;
    chk({tag, "_wbWriteData"}, wbWriteData, expData);
    chk({tag, "_wbWriteAddr"}, 16'(wbWriteAddr), 16'(expAddr));
    chk({tag, "_wbWriteEn"}, 16'(wbWriteEn), 16'(expEn));
    chk({tag, "_outputWB_post"}, outputWB, modelWb());
    @(negedge clock);
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 3'd0);
    @(negedge clock);
    // reset state, with non-zero inputs that reset must override
    drive(1'b0, 1'b0, 16'h1234, 16'hABCD, 2'b00, 1'b1, 3'd6);
    cycle("reset");
    chk("reset_zero_data", wbWriteData, 16'h0000);

    // ALU select, then first capture after release
    drive(1'b1, 1'b0, 16'h0001, 16'h0003, 2'b00, 1'b1, 3'd5);
    #1 chk("alu_direct", outputWB, 16'h0003);
    cycle("alu");
    chk("alu_data_const", wbWriteData, 16'h0003);
    chk("alu_en_const", 16'(wbWriteEn), 16'h0001);
    chk("alu_addr_const", 16'(wbWriteAddr), 16'h0005);

    // memory word select
    drive(1'b1, 1'b1, 16'h0001, 16'h0003, 2'b00, 1'b1, 3'd2);
    cycle("mem_word");
    chk("mem_word_const", wbWriteData, 16'h0001);
    drive(1'b1, 1'b1, 16'h12F0, 16'h0003, 2'b11, 1'b1, 3'd2);
    cycle("mem_word11");
    chk("mem_word11_const", wbWriteData, 16'h12F0);

    // signed and unsigned byte loads
    drive(1'b1, 1'b1, 16'h12F0, 16'h0003, 2'b01, 1'b1, 3'd3);
    cycle("lb");
    chk("lb_const", wbWriteData, 16'hFFF0);
    drive(1'b1, 1'b1, 16'h12F0, 16'h0003, 2'b10, 1'b1, 3'd3);
    cycle("lbu");
    chk("lbu_const", wbWriteData, 16'h00F0);
    drive(1'b1, 1'b1, 16'hAA7F, 16'h0003, 2'b01, 1'b1, 3'd3);
    cycle("lb_pos");
    chk("lb_pos_const", wbWriteData, 16'h007F);

    // memSize ignored on the ALU path
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 1'b0, 16'h12F0, 16'h5A5A, 2'(s), 1'b0, 3'd1);
      #1 chk("alu_ignores_size", outputWB, 16'h5A5A);
      @(negedge clock);
    end

    // register 0 never written, address and data still update
    drive(1'b1, 1'b0, 16'h0000, 16'h7777, 2'b00, 1'b1, 3'd0);
    cycle("reg0");
    chk("reg0_en_const", 16'(wbWriteEn), 16'h0000);
    chk("reg0_data_const", wbWriteData, 16'h7777);

    // reset pulse mid-stream
    drive(1'b1, 1'b0, 16'h0000, 16'h1111, 2'b00, 1'b1, 3'd4);
    cycle("pre_reset");
    drive(1'b0, 1'b0, 16'h0000, 16'hBEEF, 2'b00, 1'b1, 3'd4);
    cycle("mid_reset");
    chk("mid_reset_wb", outputWB, 16'hBEEF);
    chk("mid_reset_data_const", wbWriteData, 16'h0000);
    chk("mid_reset_en_const", 16'(wbWriteEn), 16'h0000);
    reset = 1'b1;
    cycle("post_reset");
    chk("post_reset_data_const", wbWriteData, 16'hBEEF);

    // MemtoReg toggle within a cycle: comb moves now, registers wait for the edge
    drive(1'b1, 1'b0, 16'h00C3, 16'h4242, 2'b10, 1'b1, 3'd7);
    #1 chk("toggle_alu", outputWB, 16'h4242);
    chk("toggle_hold0", wbWriteData, 16'hBEEF);
    MemtoReg = 1'b1;
    #1 chk("toggle_mem", outputWB, 16'h00C3);
    chk("toggle_hold1", wbWriteData, 16'hBEEF);
    @(negedge clock);
    cycle("toggle_edge");
    chk("toggle_edge_const", wbWriteData, 16'h00C3);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) != 0), 1'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom), 1'($urandom), 3'($urandom));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, 16, datapath width.
REQ-002 Parameter REG_ADDR_WIDTH, 3, register-file address width.
REQ-003 Reset: one clock; reset is synchronous and active-low.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 MemtoReg  in  1  result select: 1 = memory data, 0 = ALU result.
REQ-007 dataReadMEM  in  DATA_WIDTH  data read by the MEM stage.
REQ-008 resultALU  in  DATA_WIDTH  ALU result forwarded from MEM.
REQ-009 memSize  in  2  load width: 00 = word, 01 = signed low byte, 10 = unsigned low byte, 11 = word.
REQ-010 RegWrite  in  1  instruction writes the register file.
REQ-011 writeRegIn  in  REG_ADDR_WIDTH  destination register address.
REQ-012 outputWB  out  DATA_WIDTH  combinational write-back value.
REQ-013 wbWriteEn  out  1  registered register-file write enable.
REQ-014 wbWriteAddr  out  REG_ADDR_WIDTH  registered destination address.
REQ-015 wbWriteData  out  DATA_WIDTH  registered write-back value.

Function
REQ-016 Load formatting: memSize 00/11 passes dataReadMEM unchanged, 01 sign-extends bits [7:0], 10 zero-extends bits [7:0].
REQ-017 outputWB SHALL equal the formatted memory data when MemtoReg = 1 and resultALU when MemtoReg = 0.
REQ-018 outputWB SHALL be purely combinational, zero latency, with no dependence on clock or reset.
REQ-019 memSize SHALL have no effect when MemtoReg = 0.
REQ-020 On each rising clock edge with reset high, wbWriteData <= outputWB, wbWriteAddr <= writeRegIn, wbWriteEn <= RegWrite, giving one-cycle latency.
REQ-021 wbWriteEn SHALL be forced to 0 when writeRegIn = 0, because register 0 is never written; wbWriteAddr and wbWriteData still update.
REQ-022 Unknown or X select inputs need no defined result; all defined input combinations are fully specified above.
REQ-023 There is no handshake or stall: every cycle captures new inputs.

Reset
REQ-024 When reset = 0 at a rising edge, wbWriteEn, wbWriteAddr and wbWriteData SHALL become 0 on that edge, overriding all inputs.
REQ-025 outputWB SHALL continue to follow its inputs while reset is asserted.
REQ-026 The first capture after reset is released SHALL occur on the first rising edge at which reset = 1.

Verification
REQ-027 MemtoReg=0, dataReadMEM=0x0001, resultALU=0x0003 -> outputWB=0x0003 immediately; wbWriteData=0x0003 after the next edge.
REQ-028 MemtoReg=1, memSize=00, dataReadMEM=0x0001, resultALU=0x0003 -> outputWB=0x0001.
REQ-029 MemtoReg=1, dataReadMEM=0x12F0, memSize=01 -> 0xFFF0; memSize=10 -> 0x00F0.
REQ-030 RegWrite=1, writeRegIn=5 -> wbWriteEn=1 and wbWriteAddr=5 after one edge; writeRegIn=0 -> wbWriteEn=0.
REQ-031 reset=0 for one edge mid-stream with RegWrite=1 and resultALU=0xBEEF -> registered outputs are 0; outputWB=0xBEEF throughout.
REQ-032 Toggle MemtoReg between edges -> outputWB changes within the same cycle; registered outputs change only at the edge.
